wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that drives the single register-file write port of the pipelined MIPS core. It merges the in-order pipeline write-back stream with out-of-order "late" results (multi-cycle units) buffered in a small FIFO, and registers the winning write onto the GRF write port. It also answers decode-stage queries on whether a source register still has a write pending, so hazard logic can stall.

## Interface
- `DEPTH`, 4: late-result FIFO entries (power of two, ≥2).
- `STARVE_MAX`, 8: cycles a non-empty FIFO head may lose arbitration before it is forced through.
- `clk`  in  1  clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pipe_valid`  in  1  pipeline write-back request this cycle.
- `pipe_rd` / `pipe_data` / `pipe_pc`  in  5/32/32  pipeline destination, value, instruction PC.
- `wb_stall`  out  1  pipeline write not taken this cycle; source must hold the same request next cycle.
- `late_valid`  in  1  late result offered.
- `late_ready`  out  1  FIFO can accept; transfer when `late_valid && late_ready`.
- `late_rd` / `late_data` / `late_pc`  in  5/32/32  late destination, value, PC.
- `grf_we`  out  1  GRF write enable (registered).
- `grf_rd` / `grf_wdata` / `grf_pc`  out  5/32/32  GRF write address, data, PC (registered).
- `q_rs`, `q_rt`  in  5  decode source registers.
- `q_rs_pend`, `q_rt_pend`  out  1  write to that register still pending.

## Operation
- Pipe request eligible iff `pipe_valid && pipe_rd != 0`; `pipe_valid` with `pipe_rd == 0` is consumed silently, no write, no stall.
- Late transfer with `late_rd == 0` is accepted and discarded (not enqueued).
- Arbitration each cycle: FIFO wins if non-empty and (pipe not eligible or starve counter == `STARVE_MAX`); else pipe wins.
- `wb_stall` = pipe eligible && FIFO wins (combinational).
- Starve counter: +1 each cycle FIFO non-empty and loses; cleared on every pop or when FIFO empty; saturates at `STARVE_MAX`.
- `late_ready` = !full && !reset; full judged on current count, so no enqueue while full even if a pop occurs that cycle.
- Simultaneous push and pop on a non-full FIFO: count unchanged, order preserved.
- Pend query: `q_x_pend` = `q_x != 0` && (matches any valid FIFO entry's rd, or `grf_we && grf_rd == q_x`). Combinational.
- Upstream guarantees no pipe write to an rd with a pending FIFO entry (decode stalls on pend); bench asserts it.

## Timing
- Pipe request winning in cycle N → `grf_*` valid in N+1; GRF commits at end of N+1.
- Late transfer in cycle N → earliest arbitration N+1 → earliest `grf_we` N+2. No FIFO bypass.
- `grf_we` is a one-cycle pulse per write; de-asserted otherwise; `grf_rd/wdata/pc` hold last value.
- Reset (any cycle, incl. mid-stream): FIFO emptied, starve counter 0, `grf_we`=0, `grf_rd`=0, `grf_wdata`=0, `grf_pc`=0 at next edge; `late_ready`=0 and `wb_stall`=0 while `reset` high; pend outputs 0 after reset edge.

## Configuration
- `WB_ARBITER_TRACE_EN`: defined → on each `grf_we` cycle, `$display("%d@%h: $%d <= %h", $time, grf_pc, grf_rd, grf_wdata)` at the clock edge. Undefined → no simulation output; RTL otherwise identical.

## Structure
- Shared package `wb_pkg`: `wb_entry_t` struct {rd[4:0], data[31:0], pc[31:0]}, default `DEPTH`/`STARVE_MAX` constants.
- One sub-module `wb_fifo` (circular buffer, DEPTH entries, head/tail/count, exposes all entries' valid+rd for pend lookup).

## Test plan
- After reset, pipe_valid=1 rd=5 data=0x1234 pc=0x3000 → next cycle grf_we=1 rd=5 wdata=0x1234 pc=0x3000; q_rs=5 pend=1 that cycle.
- Late rd=8 data=0xAA, pipe idle → grf_we with rd=8 two cycles after transfer; q_rt=8 pend=1 until write cycle ends.
- 5 late pushes with DEPTH=4, no pops (pipe busy) → late_ready=0 after 4th; 5th held until a pop.
- FIFO holds rd=9, pipe eligible every cycle → 8 pipe writes, then wb_stall=1 one cycle, rd=9 written, held pipe request written next cycle.
- pipe rd=0 and late rd=0 → no grf_we, no stall, FIFO count unchanged.
- Reset asserted with 3 FIFO entries and grf_we=1 → next cycle grf_we=0, pend=0, late_ready=1 after reset drops.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default sizing for the write-back arbiter and its late-result FIFO.
package wb_pkg;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_entry_t;

  localparam int WB_ENTRY_W    = $bits(wb_entry_t);
  localparam int WB_DEPTH      = 4;
  localparam int WB_STARVE_MAX = 8;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of late write-back results; exposes every slot's valid bit and rd
// so the arbiter can answer pending-write queries.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic [WB_ENTRY_W-1:0]   push_entry,
  input  logic                    pop,
  output logic [WB_ENTRY_W-1:0]   head_entry,
  output logic                    empty,
  output logic                    full,
  output logic [DEPTH-1:0]        ent_valid,
  output logic [DEPTH*5-1:0]      ent_rd
);

  localparam int PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty      = (count == '0);
  assign full       = (count == (PTR_W+1)'(DEPTH));
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_entry = mem[head];

  // A slot is live when its distance from head is below the occupancy count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign ent_valid[i]       = ({1'b0, PTR_W'(i) - head} < count);
    assign ent_rd[i*5 +: 5]   = mem[i].rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= wb_entry_t'(push_entry);
        tail      <= tail + 1'b1;
      end
      if (do_pop) begin
        head <= head + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges in-order pipeline write-backs with buffered late results onto the single GRF write port.
// Optional: define WB_ARBITER_TRACE_EN to print each committed register write.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH      = WB_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pipe_valid,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic [31:0] pipe_pc,
  output logic        wb_stall,
  input  logic        late_valid,
  output logic        late_ready,
  input  logic [4:0]  late_rd,
  input  logic [31:0] late_data,
  input  logic [31:0] late_pc,
  output logic        grf_we,
  output logic [4:0]  grf_rd,
  output logic [31:0] grf_wdata,
  output logic [31:0] grf_pc,
  input  logic [4:0]  q_rs,
  input  logic [4:0]  q_rt,
  output logic        q_rs_pend,
  output logic        q_rt_pend
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                  pipe_elig;
  logic                  fifo_wins;
  logic                  fifo_push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [WB_ENTRY_W-1:0] head_bits;
  wb_entry_t             head;
  wb_entry_t             push_entry;
  logic [DEPTH-1:0]      ent_valid;
  logic [DEPTH*5-1:0]    ent_rd;
  logic [SW-1:0]         starve;

  assign pipe_elig  = pipe_valid && (pipe_rd != 5'd0);
  assign fifo_wins  = !fifo_empty && (!pipe_elig || (starve == SW'(STARVE_MAX)));
  assign wb_stall   = pipe_elig && fifo_wins && !reset;
  assign late_ready = !fifo_full && !reset;
  // Writes to $0 are accepted but never buffered.
  assign fifo_push  = late_valid && late_ready && (late_rd != 5'd0);
  assign push_entry = '{rd: late_rd, data: late_data, pc: late_pc};
  assign head       = wb_entry_t'(head_bits);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_wins),
    .head_entry (head_bits),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .ent_valid  (ent_valid),
    .ent_rd     (ent_rd)
  );

  always_comb begin
    q_rs_pend = grf_we && (grf_rd == q_rs);
    q_rt_pend = grf_we && (grf_rd == q_rt);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i*5 +: 5] == q_rs)) q_rs_pend = 1'b1;
      if (ent_valid[i] && (ent_rd[i*5 +: 5] == q_rt)) q_rt_pend = 1'b1;
    end
    if (q_rs == 5'd0) q_rs_pend = 1'b0;
    if (q_rt == 5'd0) q_rt_pend = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grf_we    <= 1'b0;
      grf_rd    <= 5'd0;
      grf_wdata <= 32'd0;
      grf_pc    <= 32'd0;
      starve    <= '0;
    end else begin
      grf_we <= fifo_wins || pipe_elig;
      if (fifo_wins) begin
        grf_rd    <= head.rd;
        grf_wdata <= head.data;
        grf_pc    <= head.pc;
      end else if (pipe_elig) begin
        grf_rd    <= pipe_rd;
        grf_wdata <= pipe_data;
        grf_pc    <= pipe_pc;
      end
      if (fifo_empty || fifo_wins) starve <= '0;
      else if (starve != SW'(STARVE_MAX)) starve <= starve + 1'b1;
    end
  end

`ifdef WB_ARBITER_TRACE_EN
  always @(posedge clk) begin
    if (grf_we) $display("%d@%h: $%d <= %h", $time, grf_pc, grf_rd, grf_wdata);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_wb_arbiter;

  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic [31:0] pipe_pc;
  logic        wb_stall;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_rd;
  logic [31:0] late_data;
  logic [31:0] late_pc;
  logic        grf_we;
  logic [4:0]  grf_rd;
  logic [31:0] grf_wdata;
  logic [31:0] grf_pc;
  logic [4:0]  q_rs;
  logic [4:0]  q_rt;
  logic        q_rs_pend;
  logic        q_rt_pend;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_pc    (pipe_pc),
    .wb_stall   (wb_stall),
    .late_valid (late_valid),
    .late_ready (late_ready),
    .late_rd    (late_rd),
    .late_data  (late_data),
    .late_pc    (late_pc),
    .grf_we     (grf_we),
    .grf_rd     (grf_rd),
    .grf_wdata  (grf_wdata),
    .grf_pc     (grf_pc),
    .q_rs       (q_rs),
    .q_rt       (q_rt),
    .q_rs_pend  (q_rs_pend),
    .q_rt_pend  (q_rt_pend)
  );

  always #5 clk = ~clk;

  // Reference model: pending late writes in arrival order plus the expected GRF port.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int          m_starve;
  logic        m_we;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_pc;
  logic        last_stall;

  typedef struct {
    logic        pv;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic pend_of(input logic [4:0] r);
    logic hit;
    hit = m_we && (m_rd == r);
    foreach (mq[i]) if (mq[i].rd == r) hit = 1'b1;
    return (r != 5'd0) && hit;
  endfunction

  // One clock: compare everything against the model mid-cycle, then advance the model.
  task automatic apply_stimulus();
    logic elig, fwins, ex_ready;
    int   old_size;
    ent_t e;
    @(negedge clk);
    elig     = pipe_valid && (pipe_rd != 5'd0);
    fwins    = !reset && (mq.size() != 0) && (!elig || m_starve >= STARVE_MAX);
    ex_ready = !reset && (mq.size() < DEPTH);
    if (!reset && elig) begin
      foreach (mq[i]) begin
        if (mq[i].rd == pipe_rd) begin
          errors++;
          $display("[TB] FAIL pipe_rd_pending: pipe rd %0d has a buffered late write", pipe_rd);
        end
      end
    end
    check_output("wb_stall",   wb_stall,   elig && fwins);
    check_output("late_ready", late_ready, ex_ready);
    check_output("q_rs_pend",  q_rs_pend,  pend_of(q_rs));
    check_output("q_rt_pend",  q_rt_pend,  pend_of(q_rt));
    check_output("grf_we",     grf_we,     m_we);
    check_output("grf_rd",     grf_rd,     m_rd);
    check_output("grf_wdata",  grf_wdata,  m_data);
    check_output("grf_pc",     grf_pc,     m_pc);
    last_stall = elig && fwins;
    if (reset) begin
      mq.delete();
      m_starve = 0;
      m_we = 1'b0; m_rd = '0; m_data = '0; m_pc = '0;
    end else begin
      old_size = mq.size();
      if (fwins) begin
        e = mq.pop_front();
        m_we = 1'b1; m_rd = e.rd; m_data = e.data; m_pc = e.pc;
      end else if (elig) begin
        m_we = 1'b1; m_rd = pipe_rd; m_data = pipe_data; m_pc = pipe_pc;
      end else begin
        m_we = 1'b0;
      end
      if (late_valid && ex_ready && late_rd != 5'd0)
        mq.push_back('{rd: late_rd, data: late_data, pc: late_pc});
      if (old_size == 0 || fwins) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve = m_starve + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pipe_valid = 1'b0;
    late_valid = 1'b0;
    apply_stimulus();
    reset = 1'b0;
  endtask

  initial begin
    logic accepted;
    reset = 1'b1; pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0; pipe_pc = '0;
    late_valid = 1'b0; late_rd = '0; late_data = '0; late_pc = '0;
    q_rs = '0; q_rt = '0; last_stall = 1'b0;
    @(posedge clk);
    #1;
    mq.delete(); m_starve = 0; m_we = 1'b0; m_rd = '0; m_data = '0; m_pc = '0;
    do_reset();

    // Single pipeline writes with an empty FIFO; GRF fields hold when no write.
    tbl[0] = '{1'b1, 5'd3,  32'h11,       32'h100, 1'b1, 5'd3,  32'h11,       32'h100};
    tbl[1] = '{1'b0, 5'd7,  32'h22,       32'h104, 1'b0, 5'd3,  32'h11,       32'h100};
    tbl[2] = '{1'b1, 5'd0,  32'h33,       32'h108, 1'b0, 5'd3,  32'h11,       32'h100};
    tbl[3] = '{1'b1, 5'd31, 32'hdeadbeef, 32'h10c, 1'b1, 5'd31, 32'hdeadbeef, 32'h10c};
    tbl[4] = '{1'b1, 5'd1,  32'h0,        32'h110, 1'b1, 5'd1,  32'h0,        32'h110};
    tbl[5] = '{1'b0, 5'd0,  32'h44,       32'h114, 1'b0, 5'd1,  32'h0,        32'h110};
    for (int i = 0; i < 6; i++) begin
      pipe_valid = tbl[i].pv; pipe_rd = tbl[i].rd; pipe_data = tbl[i].data; pipe_pc = tbl[i].pc;
      apply_stimulus();
      check_output("tbl_we",    grf_we,    tbl[i].e_we);
      check_output("tbl_rd",    grf_rd,    tbl[i].e_rd);
      check_output("tbl_wdata", grf_wdata, tbl[i].e_data);
      check_output("tbl_pc",    grf_pc,    tbl[i].e_pc);
    end

    // Pipeline write lands on the GRF port one cycle later and shows as pending.
    do_reset();
    q_rs = 5'd5;
    pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234; pipe_pc = 32'h3000;
    apply_stimulus();
    pipe_valid = 1'b0;
    #1;
    check_output("pipe_we",    grf_we,    1'b1);
    check_output("pipe_rd",    grf_rd,    5'd5);
    check_output("pipe_wdata", grf_wdata, 32'h1234);
    check_output("pipe_pc",    grf_pc,    32'h3000);
    check_output("pipe_pend",  q_rs_pend, 1'b1);
    apply_stimulus();

    // Late result: no bypass, written two cycles after transfer.
    q_rt = 5'd8;
    late_valid = 1'b1; late_rd = 5'd8; late_data = 32'hAA; late_pc = 32'h4000;
    apply_stimulus();
    late_valid = 1'b0;
    #1;
    check_output("late_n1_we",   grf_we,    1'b0);
    check_output("late_n1_pend", q_rt_pend, 1'b1);
    apply_stimulus();
    check_output("late_n2_we",   grf_we,    1'b1);
    check_output("late_n2_rd",   grf_rd,    5'd8);
    check_output("late_n2_data", grf_wdata, 32'hAA);
    check_output("late_n2_pend", q_rt_pend, 1'b1);
    apply_stimulus();
    check_output("late_n3_we",   grf_we,    1'b0);
    check_output("late_n3_pend", q_rt_pend, 1'b0);

    // Fill the FIFO while the pipe keeps winning; the 5th push waits for a pop.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      late_valid = 1'b1; late_rd = 5'(16 + k); late_data = 32'h500 + k; late_pc = 32'h5000 + 4*k;
      if (!last_stall) begin
        pipe_valid = 1'b1; pipe_rd = 5'(1 + k % 4); pipe_data = 32'h600 + k; pipe_pc = 32'h6000 + 4*k;
      end
      apply_stimulus();
      if (k == 3) check_output("full_ready", late_ready, 1'b0);
    end
    accepted = 1'b0;
    for (int n = 0; n < 30 && !accepted; n++) begin
      if (!last_stall) begin
        pipe_rd = 5'(1 + n % 4); pipe_data = 32'h700 + n; pipe_pc = 32'h7000 + 4*n;
      end
      #1;
      accepted = late_ready;
      apply_stimulus();
    end
    check_output("fifth_accepted", accepted, 1'b1);
    late_valid = 1'b0;
    while (last_stall) apply_stimulus();
    pipe_valid = 1'b0;
    for (int n = 0; n < 8; n++) apply_stimulus();

    // Starvation: buffered rd=9 loses eight times, then forces through once.
    do_reset();
    pipe_valid = 1'b1; pipe_rd = 5'd2; pipe_data = 32'h100; pipe_pc = 32'h8000;
    late_valid = 1'b1; late_rd = 5'd9; late_data = 32'h99; late_pc = 32'h9000;
    apply_stimulus();
    late_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      pipe_data = 32'h200 + k; pipe_pc = 32'h8004 + 4*k;
      #1;
      check_output("starve_stall", wb_stall, (k == 8));
      apply_stimulus();
    end
    check_output("starve_late_rd",   grf_rd,    5'd9);
    check_output("starve_late_data", grf_wdata, 32'h99);
    #1;
    check_output("starve_release", wb_stall, 1'b0);
    apply_stimulus();
    check_output("starve_held_rd",   grf_rd,    5'd2);
    check_output("starve_held_data", grf_wdata, 32'h208);
    pipe_valid = 1'b0;

    // Writes to $0 from either source are dropped silently.
    apply_stimulus();
    pipe_valid = 1'b1; pipe_rd = 5'd0; pipe_data = 32'h1; late_valid = 1'b1; late_rd = 5'd0;
    #1;
    check_output("zero_stall", wb_stall, 1'b0);
    apply_stimulus();
    pipe_valid = 1'b0; late_valid = 1'b0;
    check_output("zero_we", grf_we, 1'b0);
    apply_stimulus();
    check_output("zero_we2", grf_we, 1'b0);

    // Reset mid-stream with three buffered entries and a live GRF write.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      pipe_valid = 1'b1; pipe_rd = 5'(1 + k); pipe_data = 32'hA0 + k; pipe_pc = 32'hA000 + 4*k;
      late_valid = 1'b1; late_rd = 5'(20 + k); late_data = 32'hB0 + k; late_pc = 32'hB000 + 4*k;
      apply_stimulus();
    end
    late_valid = 1'b0;
    q_rs = 5'd20; q_rt = 5'd22;
    pipe_rd = 5'd4;
    #1;
    check_output("pre_reset_we", grf_we, 1'b1);
    reset = 1'b1;
    #1;
    check_output("in_reset_ready", late_ready, 1'b0);
    check_output("in_reset_stall", wb_stall,   1'b0);
    apply_stimulus();
    reset = 1'b0; pipe_valid = 1'b0;
    #1;
    check_output("post_reset_we",    grf_we,     1'b0);
    check_output("post_reset_rs",    q_rs_pend,  1'b0);
    check_output("post_reset_rt",    q_rt_pend,  1'b0);
    check_output("post_reset_ready", late_ready, 1'b1);
    apply_stimulus();

    // Randomized traffic; pipe and late destinations come from disjoint ranges.
    for (int n = 0; n < 400; n++) begin
      if (!last_stall) begin
        pipe_valid = ($urandom_range(0, 3) != 0);
        pipe_rd    = 5'($urandom_range(0, 15));
        pipe_data  = $urandom;
        pipe_pc    = $urandom & 32'hFFFF_FFFC;
      end
      late_valid = ($urandom_range(0, 2) == 0);
      late_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'(16 + $urandom_range(0, 15));
      late_data  = $urandom;
      late_pc    = $urandom & 32'hFFFF_FFFC;
      q_rs       = 5'($urandom_range(0, 31));
      q_rt       = 5'($urandom_range(0, 31));
      reset      = ($urandom_range(0, 99) == 0);
      apply_stimulus();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
